// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing, window geometry and 12-bit colour definitions
// for the scan-out back end.
package vga_pkg;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = 15;

    localparam int DEF_X     = 200;
    localparam int DEF_Y     = 150;
    localparam int DEF_SCALE = 3;

    typedef logic [11:0] rgb12_t;

    localparam rgb12_t BLACK12 = 12'h000;
    localparam rgb12_t RED12   = 12'hF00;
    localparam rgb12_t GREEN12 = 12'h0F0;
    localparam rgb12_t BLUE12  = 12'h00F;

    // Offset that centres a scaled image of n pixels inside a visible span.
    function automatic int win_off(input int vis, input int scale, input int n);
        return (vis - scale * n) / 2;
    endfunction

    localparam int H_OFF = win_off(H_VIS, DEF_SCALE, DEF_X);
    localparam int V_OFF = win_off(V_VIS, DEF_SCALE, DEF_Y);

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider plus horizontal/vertical raster counters; every counter
// and derived region flag advances only on the pixel tick.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACT    = H_VIS,
    parameter int H_FRONT  = H_FP,
    parameter int H_SYNC_W = H_SYNC,
    parameter int H_BACK   = H_BP,
    parameter int V_ACT    = V_VIS,
    parameter int V_FRONT  = V_FP,
    parameter int V_SYNC_W = V_SYNC,
    parameter int V_BACK   = V_BP
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_hcnt,
    output logic [CNT_W-1:0] o_vcnt,
    output logic             o_visible,
    output logic             o_hs_raw,
    output logic             o_vs_raw
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [CNT_W-1:0] H_VIS_L = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACT + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACT + H_FRONT + H_SYNC_W);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_ACT + H_FRONT + H_SYNC_W + H_BACK - 1);

    localparam logic [CNT_W-1:0] V_VIS_L = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACT + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACT + V_FRONT + V_SYNC_W);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_ACT + V_FRONT + V_SYNC_W + V_BACK - 1);

    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic             w_tick;
    logic             w_h_last;
    logic             w_v_last;

    assign w_tick   = (r_div == DIV_LAST);
    assign w_h_last = (r_hcnt == H_LAST);
    assign w_v_last = (r_vcnt == V_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_tick) begin
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + CNT_W'(1);
            end else begin
                r_hcnt <= r_hcnt + CNT_W'(1);
            end
        end
    end

    assign o_tick    = w_tick;
    assign o_hcnt    = r_hcnt;
    assign o_vcnt    = r_vcnt;
    assign o_visible = (r_hcnt < H_VIS_L) && (r_vcnt < V_VIS_L);
    assign o_hs_raw  = !((r_hcnt >= HS_BEG) && (r_hcnt < HS_END));
    assign o_vs_raw  = !((r_vcnt >= VS_BEG) && (r_vcnt < VS_END));

endmodule

// File: rtl/vga_scanout.sv
// Scans the stored frame out as VGA: incremental RAM addressing with SCALE x SCALE
// pixel replication into a centred window, and a one-tick registered colour/sync stage.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int     X        = DEF_X,
    parameter int     Y        = DEF_Y,
    parameter int     SCALE    = DEF_SCALE,
    parameter int     CLK_DIV  = 4,
    parameter rgb12_t BORDER   = BLACK12,
    parameter int     H_ACT    = H_VIS,
    parameter int     H_FRONT  = H_FP,
    parameter int     H_SYNC_W = H_SYNC,
    parameter int     H_BACK   = H_BP,
    parameter int     V_ACT    = V_VIS,
    parameter int     V_FRONT  = V_FP,
    parameter int     V_SYNC_W = V_SYNC,
    parameter int     V_BACK   = V_BP
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] vaddr,
    input  logic [11:0]       vdata,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              fresh
);

    localparam int WIN_H_OFF = win_off(H_ACT, SCALE, X);
    localparam int WIN_V_OFF = win_off(V_ACT, SCALE, Y);

    localparam logic [CNT_W-1:0] WIN_H0  = CNT_W'(WIN_H_OFF);
    localparam logic [CNT_W-1:0] WIN_H1  = CNT_W'(WIN_H_OFF + SCALE * X - 1);
    localparam logic [CNT_W-1:0] WIN_V0  = CNT_W'(WIN_V_OFF);
    localparam logic [CNT_W-1:0] WIN_V1  = CNT_W'(WIN_V_OFF + SCALE * Y - 1);
    localparam logic [CNT_W-1:0] FRESH_V = CNT_W'(V_ACT);

    localparam int SC_W  = (SCALE > 2) ? $clog2(SCALE) : 1;
    localparam int COL_W = (X > 2) ? $clog2(X) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCALE - 1);

    logic             w_tick;
    logic [CNT_W-1:0] w_hcnt;
    logic [CNT_W-1:0] w_vcnt;
    logic             w_visible;
    logic             w_hs_raw;
    logic             w_vs_raw;
    logic             w_in_win;
    logic             w_line_end;

    logic [SC_W-1:0]   r_sx;
    logic [SC_W-1:0]   r_sy;
    logic [COL_W-1:0]  r_col;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_vaddr;

    logic   r_win_d;
    logic   r_vis_d;
    logic   r_hs_d;
    logic   r_vs_d;
    rgb12_t r_rgb;
    logic   r_hs;
    logic   r_vs;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACT    (H_ACT),
        .H_FRONT  (H_FRONT),
        .H_SYNC_W (H_SYNC_W),
        .H_BACK   (H_BACK),
        .V_ACT    (V_ACT),
        .V_FRONT  (V_FRONT),
        .V_SYNC_W (V_SYNC_W),
        .V_BACK   (V_BACK)
    ) u_timing (
        .i_clk     (clk),
        .i_rst     (rst),
        .o_tick    (w_tick),
        .o_hcnt    (w_hcnt),
        .o_vcnt    (w_vcnt),
        .o_visible (w_visible),
        .o_hs_raw  (w_hs_raw),
        .o_vs_raw  (w_vs_raw)
    );

    assign w_in_win   = (w_hcnt >= WIN_H0) && (w_hcnt <= WIN_H1) &&
                        (w_vcnt >= WIN_V0) && (w_vcnt <= WIN_V1);
    assign w_line_end = w_in_win && (w_hcnt == WIN_H1);

    // Address uses the current sub-counters, then steps them for the next pixel;
    // outside the window nothing moves, so vaddr holds its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sx       <= '0;
            r_sy       <= '0;
            r_col      <= '0;
            r_row_base <= '0;
            r_vaddr    <= '0;
        end else if (w_tick) begin
            if (w_in_win) begin
                r_vaddr <= r_row_base + ADDR_W'(r_col);
                if (w_line_end) begin
                    r_sx  <= '0;
                    r_col <= '0;
                    if (r_sy == SC_LAST) begin
                        r_sy       <= '0;
                        r_row_base <= r_row_base + ADDR_W'(X);
                    end else begin
                        r_sy <= r_sy + SC_W'(1);
                    end
                end else if (r_sx == SC_LAST) begin
                    r_sx  <= '0;
                    r_col <= r_col + COL_W'(1);
                end else begin
                    r_sx <= r_sx + SC_W'(1);
                end
            end else if (w_vcnt == '0) begin
                r_row_base <= '0;
                r_sy       <= '0;
            end
        end
    end

    // Region decode travels alongside vaddr so it meets the RAM data one tick later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_d <= 1'b0;
            r_vis_d <= 1'b0;
            r_hs_d  <= 1'b1;
            r_vs_d  <= 1'b1;
        end else if (w_tick) begin
            r_win_d <= w_in_win;
            r_vis_d <= w_visible;
            r_hs_d  <= w_hs_raw;
            r_vs_d  <= w_vs_raw;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb <= '0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
        end else if (w_tick) begin
            if (r_win_d) begin
                r_rgb <= vdata;
            end else if (r_vis_d) begin
                r_rgb <= BORDER;
            end else begin
                r_rgb <= '0;
            end
            r_hs <= r_hs_d;
            r_vs <= r_vs_d;
        end
    end

    assign vaddr  = r_vaddr;
    assign vga_r  = r_rgb[11:8];
    assign vga_g  = r_rgb[7:4];
    assign vga_b  = r_rgb[3:0];
    assign vga_hs = r_hs;
    assign vga_vs = r_vs;
    assign fresh  = w_tick && (w_hcnt == '0) && (w_vcnt == FRESH_V);

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a reduced raster (64x40 pixel clocks, 8x8 image, 3x scale)
// so several full frames fit in a short run; the default divider of 4 is kept.
module tb_vga_scanout;

    localparam int X        = 8;
    localparam int Y        = 8;
    localparam int SCALE    = 3;
    localparam int CLK_DIV  = 4;
    localparam logic [11:0] BORDER = 12'h00F;

    localparam int H_ACT    = 48;
    localparam int H_FRONT  = 4;
    localparam int H_SYNC_W = 6;
    localparam int H_BACK   = 6;
    localparam int H_TOT_T  = 64;
    localparam int V_ACT    = 32;
    localparam int V_FRONT  = 2;
    localparam int V_SYNC_W = 2;
    localparam int V_BACK   = 4;
    localparam int V_TOT_T  = 40;

    // Centred window: (48 - 24) / 2 and (32 - 24) / 2.
    localparam int WH0 = 12;
    localparam int WV0 = 4;
    localparam int FRAME_CLK = H_TOT_T * V_TOT_T * CLK_DIV;

    logic        clk;
    logic        rst;
    logic [14:0] vaddr;
    logic [11:0] vdata;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        fresh;

    int n;
    int vectors;
    int miscompares;
    logic [13:0] exp_q[$];

    vga_scanout #(
        .X        (X),
        .Y        (Y),
        .SCALE    (SCALE),
        .CLK_DIV  (CLK_DIV),
        .BORDER   (BORDER),
        .H_ACT    (H_ACT),
        .H_FRONT  (H_FRONT),
        .H_SYNC_W (H_SYNC_W),
        .H_BACK   (H_BACK),
        .V_ACT    (V_ACT),
        .V_FRONT  (V_FRONT),
        .V_SYNC_W (V_SYNC_W),
        .V_BACK   (V_BACK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .vaddr  (vaddr),
        .vdata  (vdata),
        .vga_r  (vga_r),
        .vga_g  (vga_g),
        .vga_b  (vga_b),
        .vga_hs (vga_hs),
        .vga_vs (vga_vs),
        .fresh  (fresh)
    );

    // ---------------- clock / reset / environment ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedges since reset release; sampled on negedges.
    initial n = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) n = 0;
        else     n = n + 1;
    end

    // Synchronous video RAM whose contents equal the low 12 address bits.
    initial vdata = 12'h000;
    always @(posedge clk) vdata <= vaddr[11:0];

    // ---------------- reference model ----------------
    function automatic bit in_win(input int h, input int v);
        return (h >= WH0) && (h < WH0 + SCALE * X) && (v >= WV0) && (v < WV0 + SCALE * Y);
    endfunction

    function automatic int addr_of(input int p);
        int h;
        int v;
        h = p % H_TOT_T;
        v = (p / H_TOT_T) % V_TOT_T;
        return ((v - WV0) / SCALE) * X + (h - WH0) / SCALE;
    endfunction

    // {rgb, hs, vs} the pins must carry for raster position p.
    function automatic logic [13:0] pix_exp(input int p);
        int h;
        int v;
        int a;
        logic [11:0] c;
        logic hs;
        logic vs;
        h  = p % H_TOT_T;
        v  = (p / H_TOT_T) % V_TOT_T;
        hs = !((h >= H_ACT + H_FRONT) && (h < H_ACT + H_FRONT + H_SYNC_W));
        vs = !((v >= V_ACT + V_FRONT) && (v < V_ACT + V_FRONT + V_SYNC_W));
        if (in_win(h, v)) begin
            a = addr_of(p);
            c = a[11:0];
        end else if ((h < H_ACT) && (v < V_ACT)) begin
            c = BORDER;
        end else begin
            c = 12'h000;
        end
        return {c, hs, vs};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (vaddr !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_vaddr: got %0d expected 0", vaddr);
        end
        vectors++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_rgb: got %h expected 000", {vga_r, vga_g, vga_b});
        end
        vectors++;
        if (vga_hs !== 1'b1 || vga_vs !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_sync: got hs=%b vs=%b expected hs=1 vs=1", vga_hs, vga_vs);
        end
        vectors++;
        if (fresh !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fresh: got %b expected 0", fresh);
        end
        rst = 1'b0;
    endtask

    // Whole frame: colour/sync per pixel through the scoreboard, vaddr every clock.
    task automatic test_scan_data();
        logic [13:0] got;
        logic [13:0] want;
        logic [14:0] exp_vaddr;
        int s;
        do_reset();
        exp_q.delete();
        exp_q.push_back({12'h000, 1'b1, 1'b1});
        exp_q.push_back({12'h000, 1'b1, 1'b1});
        exp_vaddr = 15'd0;
        for (int k = 0; k < CLK_DIV * (H_TOT_T * V_TOT_T + 2); k++) begin
            s = n / CLK_DIV;
            if (n % CLK_DIV == 0) begin
                exp_q.push_back(pix_exp(s));
                want = exp_q.pop_front();
                got  = {vga_r, vga_g, vga_b, vga_hs, vga_vs};
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL scan_pixel pos=%0d (h=%0d v=%0d): got rgb=%h hs=%b vs=%b expected rgb=%h hs=%b vs=%b",
                             s - 2, (s - 2) % H_TOT_T, ((s - 2) / H_TOT_T) % V_TOT_T,
                             got[13:2], got[1], got[0], want[13:2], want[1], want[0]);
                end
                if (s >= 1 && in_win((s - 1) % H_TOT_T, ((s - 1) / H_TOT_T) % V_TOT_T)) begin
                    exp_vaddr = 15'(addr_of(s - 1));
                end
            end
            vectors++;
            if (vaddr !== exp_vaddr || int'(vaddr) > X * Y - 1) begin
                miscompares++;
                $display("FAIL scan_vaddr clk=%0d: got %0d expected %0d", n, vaddr, exp_vaddr);
            end
            @(negedge clk);
        end
    endtask

    // Three frames: sync widths and periods, vsync line placement, fresh pulses.
    task automatic test_frame_timing();
        int hs_fall;
        int vs_fall;
        int fr_last;
        int fresh_cnt;
        int s;
        logic hs_prev;
        logic vs_prev;
        logic fr_prev;
        do_reset();
        hs_fall   = -1;
        vs_fall   = -1;
        fr_last   = -1;
        fresh_cnt = 0;
        hs_prev   = 1'b1;
        vs_prev   = 1'b1;
        fr_prev   = 1'b0;
        for (int k = 0; k < 3 * FRAME_CLK; k++) begin
            s = n / CLK_DIV;
            if (hs_prev && !vga_hs) begin
                if (hs_fall >= 0) begin
                    vectors++;
                    if (n - hs_fall != H_TOT_T * CLK_DIV) begin
                        miscompares++;
                        $display("FAIL line_period: got %0d clk expected %0d", n - hs_fall, H_TOT_T * CLK_DIV);
                    end
                end
                hs_fall = n;
            end
            if (!hs_prev && vga_hs) begin
                vectors++;
                if (n - hs_fall != H_SYNC_W * CLK_DIV) begin
                    miscompares++;
                    $display("FAIL hs_width: got %0d clk expected %0d", n - hs_fall, H_SYNC_W * CLK_DIV);
                end
            end
            if (vs_prev && !vga_vs) begin
                vectors++;
                if (vs_fall < 0) begin
                    if (n != CLK_DIV * ((V_ACT + V_FRONT) * H_TOT_T + 2)) begin
                        miscompares++;
                        $display("FAIL vs_first_line: got clk %0d expected %0d", n,
                                 CLK_DIV * ((V_ACT + V_FRONT) * H_TOT_T + 2));
                    end
                end else if (n - vs_fall != FRAME_CLK) begin
                    miscompares++;
                    $display("FAIL frame_period: got %0d clk expected %0d", n - vs_fall, FRAME_CLK);
                end
                vs_fall = n;
            end
            if (!vs_prev && vga_vs) begin
                vectors++;
                if (n - vs_fall != V_SYNC_W * H_TOT_T * CLK_DIV) begin
                    miscompares++;
                    $display("FAIL vs_width: got %0d clk expected %0d", n - vs_fall, V_SYNC_W * H_TOT_T * CLK_DIV);
                end
            end
            if (fresh) begin
                fresh_cnt++;
                vectors++;
                if (fr_prev || (n % CLK_DIV != CLK_DIV - 1) || (s % H_TOT_T != 0) ||
                    ((s / H_TOT_T) % V_TOT_T != V_ACT)) begin
                    miscompares++;
                    $display("FAIL fresh_position: got pulse at clk %0d (h=%0d v=%0d div=%0d prev=%b) expected h=0 v=%0d div=%0d single clk",
                             n, s % H_TOT_T, (s / H_TOT_T) % V_TOT_T, n % CLK_DIV, fr_prev, V_ACT, CLK_DIV - 1);
                end
                if (fr_last >= 0) begin
                    vectors++;
                    if (n - fr_last != FRAME_CLK) begin
                        miscompares++;
                        $display("FAIL fresh_interval: got %0d clk expected %0d", n - fr_last, FRAME_CLK);
                    end
                end
                fr_last = n;
            end
            hs_prev = vga_hs;
            vs_prev = vga_vs;
            fr_prev = fresh;
            @(negedge clk);
        end
        vectors++;
        if (fresh_cnt != 3) begin
            miscompares++;
            $display("FAIL fresh_count: got %0d expected 3", fresh_cnt);
        end
    endtask

    // Reset in the middle of a window line, then restart from line 0.
    task automatic test_mid_reset();
        int target;
        int found;
        do_reset();
        target = CLK_DIV * (20 * H_TOT_T + 30) + 1;
        for (int k = 0; k < target + 8 && n != target; k++) @(negedge clk);
        vectors++;
        if (n != target) begin
            miscompares++;
            $display("FAIL mid_reset_reach: got clk %0d expected %0d", n, target);
        end
        vectors++;
        if (int'(vaddr) != addr_of(n / CLK_DIV - 1)) begin
            miscompares++;
            $display("FAIL mid_reset_pre_vaddr: got %0d expected %0d", vaddr, addr_of(n / CLK_DIV - 1));
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (vaddr !== 15'd0 || {vga_r, vga_g, vga_b} !== 12'h000) begin
            miscompares++;
            $display("FAIL mid_reset_async: got vaddr=%0d rgb=%h expected vaddr=0 rgb=000", vaddr, {vga_r, vga_g, vga_b});
        end
        vectors++;
        if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || fresh !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_sync: got hs=%b vs=%b fresh=%b expected 1 1 0", vga_hs, vga_vs, fresh);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        found = -1;
        for (int k = 0; k < 2 * H_TOT_T * CLK_DIV && found < 0; k++) begin
            if (!vga_hs) found = n;
            else @(negedge clk);
        end
        vectors++;
        if (found != CLK_DIV * (H_ACT + H_FRONT + 2)) begin
            miscompares++;
            $display("FAIL hs_after_reset: got first low at clk %0d expected %0d", found,
                     CLK_DIV * (H_ACT + H_FRONT + 2));
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        test_reset();
        test_scan_data();
        test_frame_timing();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
